// File: rtl/row_s2p_collector.sv
`default_nettype none
// ============================================================================
// Module   : row_s2p_collector
// Purpose  : Per-row serial-to-parallel deserializer. Each lane assembles
//            (BITS_ADC+1)-bit words MSB first. Completed words are held in a
//            single-entry buffer per lane. A round-robin arbiter moves them,
//            tagged with the row index, into a first-word-fall-through FIFO
//            that drives a valid/ready output port.
// Revision : 1.0  initial release
// ============================================================================
module row_s2p_collector #(
  parameter int ROW_NUM    = 8,
  parameter int BITS_ADC   = 12,
  parameter int ROW_IDX_W  = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int OUT_W      = ROW_IDX_W + BITS_ADC + 1
) (
  input  logic                          clk_50M,
  input  logic                          rst_n,
  input  logic                          sample_stb,
  input  logic [ROW_NUM-1:0]            s_data,
  input  logic [ROW_NUM-1:0]            data_valid,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          clr_stat,
  output logic [ROW_NUM-1:0]            frame_err,
  output logic [ROW_NUM-1:0]            lane_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int WORD_W = BITS_ADC + 1;
  localparam int CNT_W  = $clog2(WORD_W);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;
  localparam int SUM_W  = ROW_IDX_W + 1;

  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(BITS_ADC);
  localparam logic [LVL_W-1:0]     LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [ROW_IDX_W-1:0] LANE_LAST = ROW_IDX_W'(ROW_NUM - 1);
  localparam logic [SUM_W-1:0]     LANE_CNT  = SUM_W'(ROW_NUM);

  // Lane <-> arbiter glue
  logic [ROW_NUM-1:0]  pend_vec;
  logic [ROW_NUM-1:0]  abort_vec;
  logic [ROW_NUM-1:0]  drop_vec;
  logic [ROW_NUM-1:0]  grant;
  logic [WORD_W-1:0]   hold_arr [ROW_NUM];

  // Arbiter state
  logic [ROW_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ROW_IDX_W-1:0] gnt_idx;
  logic [SUM_W-1:0]     srch_idx;
  logic                 gnt_any;

  // FIFO state
  logic [OUT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [OUT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic [OUT_W-1:0]  push_data;

  // Sticky status
  logic [ROW_NUM-1:0] frame_err_q, frame_err_d;
  logic [ROW_NUM-1:0] lane_ovf_q, lane_ovf_d;

  // --------------------------------------------------------------------------
  // Per-lane deserializer and holding register
  // --------------------------------------------------------------------------
  for (genvar x = 0; x < ROW_NUM; x++) begin : g_lane
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              abort_w;
    logic              drop_w;

    // Shift, count and hand completed words to the holding register
    always_comb begin
      shift_d = shift_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      abort_w = 1'b0;
      drop_w  = 1'b0;
      // A grant empties the holding register unless a new word lands below
      if (grant[x]) begin
        pend_d = 1'b0;
      end
      if (sample_stb) begin
        if (data_valid[x]) begin
          shift_d = {shift_q[WORD_W-2:0], s_data[x]};
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (pend_q && !grant[x]) begin
              // Held word has not left yet: keep it, lose the new one
              drop_w = 1'b1;
            end else begin
              hold_d = {shift_q[WORD_W-2:0], s_data[x]};
              pend_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
          if (cnt_q != '0) begin
            abort_w = 1'b1;
          end
        end
      end
    end

    // Lane registers
    always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
        shift_q <= '0;
        hold_q  <= '0;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
      end else begin
        shift_q <= shift_d;
        hold_q  <= hold_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
      end
    end

    assign pend_vec[x]  = pend_q;
    assign abort_vec[x] = abort_w;
    assign drop_vec[x]  = drop_w;
    assign hold_arr[x]  = hold_q;
  end

  // --------------------------------------------------------------------------
  // Round-robin arbiter
  // --------------------------------------------------------------------------

  // Find the first pending lane at or after the pointer, wrapping at ROW_NUM
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    srch_idx = '0;
    rr_ptr_d = rr_ptr_q;
    if (!fifo_full) begin
      for (int i = 0; i < ROW_NUM; i++) begin
        srch_idx = {1'b0, rr_ptr_q} + SUM_W'(i);
        if (srch_idx >= LANE_CNT) begin
          srch_idx = srch_idx - LANE_CNT;
        end
        if (!gnt_any && pend_vec[srch_idx[ROW_IDX_W-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = srch_idx[ROW_IDX_W-1:0];
        end
      end
      if (gnt_any) begin
        grant[gnt_idx] = 1'b1;
        rr_ptr_d = (gnt_idx == LANE_LAST) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Arbiter pointer register
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // --------------------------------------------------------------------------
  assign fifo_full = (level_q == LVL_FULL);
  assign push      = gnt_any;
  assign push_data = {gnt_idx, hold_arr[gnt_idx]};
  assign pop       = out_valid & out_ready;

  // Write/read pointers and occupancy; a same-cycle pop never frees a slot
  // for this cycle's push because the grant already saw the full level
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO registers
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;

  // --------------------------------------------------------------------------
  // Sticky status flags
  // --------------------------------------------------------------------------

  // Clear first, then OR in this cycle's events so a set wins over clr_stat
  always_comb begin
    frame_err_d = (clr_stat ? '0 : frame_err_q) | abort_vec;
    lane_ovf_d  = (clr_stat ? '0 : lane_ovf_q)  | drop_vec;
  end

  // Status registers
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= '0;
      lane_ovf_q  <= '0;
    end else begin
      frame_err_q <= frame_err_d;
      lane_ovf_q  <= lane_ovf_d;
    end
  end

  assign frame_err = frame_err_q;
  assign lane_ovf  = lane_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_row_s2p_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_s2p_collector
// Purpose  : Self-checking bench for row_s2p_collector. Expected output words
//            are queued as stimulus is driven and compared as the DUT pops.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_row_s2p_collector;

  localparam int ROW_NUM    = 8;
  localparam int BITS_ADC   = 12;
  localparam int ROW_IDX_W  = 3;
  localparam int FIFO_DEPTH = 16;
  localparam int OUT_W      = 16;

  logic             clk_50M = 1'b0;
  logic             rst_n;
  logic             sample_stb;
  logic [7:0]       s_data;
  logic [7:0]       data_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             clr_stat;
  logic [7:0]       frame_err;
  logic [7:0]       lane_ovf;
  logic [4:0]       fifo_level;

  row_s2p_collector #(
    .ROW_NUM    (ROW_NUM),
    .BITS_ADC   (BITS_ADC),
    .ROW_IDX_W  (ROW_IDX_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .OUT_W      (OUT_W)
  ) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .sample_stb (sample_stb),
    .s_data     (s_data),
    .data_valid (data_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_stat   (clr_stat),
    .frame_err  (frame_err),
    .lane_ovf   (lane_ovf),
    .fifo_level (fifo_level)
  );

  always #10 clk_50M = ~clk_50M;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;
  logic [12:0] tx_word [8];

  typedef struct {
    int          lane;
    logic [12:0] word;
    logic [15:0] exp_out;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic push_exp(input int lane, input logic [12:0] word);
    exp_q.push_back({3'(lane), word});
  endtask

  // Shift bits [12-first .. 12-first-nbits+1] of tx_word on the masked lanes
  task automatic drive_bits(input logic [7:0] mask, input int first, input int nbits);
    for (int b = first; b < first + nbits; b++) begin
      sample_stb = 1'b1;
      data_valid = mask;
      for (int l = 0; l < 8; l++) s_data[l] = tx_word[l][12-b];
      step();
    end
    sample_stb = 1'b0;
    data_valid = '0;
    s_data     = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      step();
      n++;
    end
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    sample_stb = 1'b0;
    data_valid = '0;
    s_data     = '0;
    out_ready  = 1'b0;
    clr_stat   = 1'b0;
    exp_q.delete();
    for (int l = 0; l < 8; l++) tx_word[l] = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  // Scoreboard: every accepted output word must match the queue head
  always @(negedge clk_50M) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          failures++;
          $display("FAIL out_data: got 0x%0h expected 0x%0h", out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    vecs[0] = '{lane: 2, word: 13'h1ABC, exp_out: 16'h5ABC};
    vecs[1] = '{lane: 0, word: 13'h0001, exp_out: 16'h0001};
    vecs[2] = '{lane: 7, word: 13'h1FFF, exp_out: 16'hFFFF};
    vecs[3] = '{lane: 5, word: 13'h0AAA, exp_out: 16'hAAAA};
    vecs[4] = '{lane: 3, word: 13'h1555, exp_out: 16'h7555};
    vecs[5] = '{lane: 1, word: 13'h0000, exp_out: 16'h2000};
    vecs[6] = '{lane: 6, word: 13'h1000, exp_out: 16'hD000};

    rst_n = 1'b1;
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_lane_ovf", 32'(lane_ovf), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);

    // Single words from the table, with 2-clock latency check
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      for (int l = 0; l < 8; l++) tx_word[l] = '0;
      tx_word[vecs[i].lane] = vecs[i].word;
      exp_q.push_back(vecs[i].exp_out);
      m = 8'h01 << vecs[i].lane;
      drive_bits(m, 0, 13);
      chk("lat_e0_valid", 32'(out_valid), 32'd0);
      step();
      chk("lat_e1_valid", 32'(out_valid), 32'd1);
      chk("lat_e1_level", 32'(fifo_level), 32'd1);
      drain("single");
    end

    // Simultaneous completion on all lanes, then a rotated pointer
    do_reset();
    out_ready = 1'b1;
    for (int l = 0; l < 8; l++) begin tx_word[l] = 13'h0100 + 13'(l); push_exp(l, tx_word[l]); end
    drive_bits(8'hFF, 0, 13);
    drain("simul1");
    for (int l = 0; l < 8; l++) begin tx_word[l] = 13'h0180 + 13'(l); push_exp(l, tx_word[l]); end
    drive_bits(8'hFF, 0, 13);
    drain("simul2");
    tx_word[2] = 13'h0ABC;
    push_exp(2, 13'h0ABC);
    drive_bits(8'h04, 0, 13);
    drain("simul_lane2");
    for (int l = 0; l < 8; l++) tx_word[l] = 13'h0200 + 13'(l);
    for (int k = 0; k < 8; k++) push_exp((k + 3) % 8, tx_word[(k + 3) % 8]);
    drive_bits(8'hFF, 0, 13);
    drain("simul_rr");
    chk("simul_ovf", 32'(lane_ovf), 32'd0);

    // Frame abort on lane 5, then recovery and clear
    do_reset();
    out_ready = 1'b1;
    tx_word[5] = 13'h1234;
    drive_bits(8'h20, 0, 6);
    sample_stb = 1'b1;
    step();
    sample_stb = 1'b0;
    chk("abort_frame_err", 32'(frame_err), 32'h20);
    repeat (20) step();
    chk("abort_no_word", 32'(out_valid), 32'd0);
    tx_word[5] = 13'h0F0F;
    push_exp(5, 13'h0F0F);
    drive_bits(8'h20, 0, 13);
    drain("abort_recover");
    chk("abort_sticky", 32'(frame_err), 32'h20);
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    chk("abort_clear", 32'(frame_err), 32'd0);
    // Abort on lane 4 in the same cycle as clr_stat: the set wins
    tx_word[4] = 13'h1FFF;
    drive_bits(8'h10, 0, 3);
    sample_stb = 1'b1;
    clr_stat   = 1'b1;
    step();
    sample_stb = 1'b0;
    clr_stat   = 1'b0;
    chk("set_beats_clear", 32'(frame_err), 32'h10);

    // Backpressure: FIFO fills, holding registers fill, then overflow
    do_reset();
    out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      for (int l = 0; l < 8; l++) begin
        tx_word[l] = 13'(b * 256 + l * 16 + 3);
        if (b < 4) push_exp(l, tx_word[l]);
      end
      drive_bits(8'hFF, 0, 13);
      if (b == 3) chk("bp_no_ovf_yet", 32'(lane_ovf), 32'd0);
    end
    step();
    chk("bp_level_full", 32'(fifo_level), 32'd16);
    chk("bp_lane_ovf", 32'(lane_ovf), 32'hFF);
    chk("bp_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_first_pop", 32'(fifo_level), 32'd15);
    step();
    chk("bp_push_pop", 32'(fifo_level), 32'd15);
    drain("bp_drain");
    chk("bp_ovf_sticky", 32'(lane_ovf), 32'hFF);
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    chk("bp_ovf_clear", 32'(lane_ovf), 32'd0);

    // Grant/complete collision on lane 0
    do_reset();
    out_ready = 1'b0;
    for (int b = 4; b <= 5; b++) begin
      for (int l = 0; l < 8; l++) begin tx_word[l] = 13'(b * 256 + l); push_exp(l, tx_word[l]); end
      drive_bits(8'hFF, 0, 13);
    end
    tx_word[0] = 13'h1111;
    push_exp(0, 13'h1111);
    drive_bits(8'h01, 0, 13);
    chk("coll_level_full", 32'(fifo_level), 32'd16);
    tx_word[0] = 13'h0EEE;
    push_exp(0, 13'h0EEE);
    drive_bits(8'h01, 0, 11);
    out_ready = 1'b1;
    drive_bits(8'h01, 11, 2);
    drain("coll_drain");
    chk("coll_no_ovf", 32'(lane_ovf), 32'd0);
    chk("coll_no_ferr", 32'(frame_err), 32'd0);

    // Reset mid-frame with three words queued
    do_reset();
    out_ready = 1'b0;
    for (int l = 0; l < 3; l++) tx_word[l] = 13'h0AA0 + 13'(l);
    drive_bits(8'h07, 0, 13);
    tx_word[1] = 13'h1F00;
    drive_bits(8'h02, 0, 7);
    chk("mid_level3", 32'(fifo_level), 32'd3);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_ferr", 32'(frame_err), 32'd0);
    chk("mid_rst_ovf", 32'(lane_ovf), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    out_ready  = 1'b1;
    tx_word[1] = 13'h1357;
    push_exp(1, 13'h1357);
    drive_bits(8'h02, 0, 13);
    drain("mid_fresh");
    chk("mid_ferr_after", 32'(frame_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
